// File: rtl/npc_ctrl_pkg.sv
// Shared encodings for the NPC multi-cycle control unit: opcodes, funct3 values,
// FSM states, ALU/select one-hot encodings and the decoded-control bundle.
package npc_ctrl_pkg;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH_REQ  = 3'd1,
    ST_FETCH_WAIT = 3'd2,
    ST_EXEC       = 3'd3,
    ST_MEM_REQ    = 3'd4,
    ST_MEM_WAIT   = 3'd5,
    ST_WB         = 3'd6,
    ST_HALT       = 3'd7
  } state_e;

  // LUI pass-through lives in the top bit, so its index depends on ALU_OP_W
  localparam int unsigned ALU_ADD_BIT = 0;
  localparam int unsigned ALU_SUB_BIT = 1;

  localparam logic [1:0] SRC1_RS1     = 2'b01;
  localparam logic [1:0] SRC1_PC      = 2'b10;
  localparam logic [3:0] SRC2_RS2     = 4'b0001;
  localparam logic [3:0] SRC2_IMM_IS  = 4'b0010;
  localparam logic [3:0] SRC2_IMM_U   = 4'b0100;
  localparam logic [3:0] SRC2_CONST4  = 4'b1000;
  localparam logic [2:0] NPC_SEQ      = 3'b001;
  localparam logic [2:0] NPC_PC_IMM   = 3'b010;
  localparam logic [2:0] NPC_JALR     = 3'b100;

  typedef struct packed {
    logic       legal;
    logic       ebreak;
    logic       mem;
    logic       store;
    logic       branch;
    logic       bne;
    logic       rf_we;
    logic       rfwd_load;
    logic [1:0] src1;
    logic [3:0] src2;
    logic [2:0] npc;
    logic [1:0] mem_size;
    logic       mem_unsigned;
  } dec_t;

  function automatic logic load_ok(input logic [2:0] f3, input logic rv64);
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
      3'b011, 3'b110:                         return rv64;
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic logic store_ok(input logic [2:0] f3, input logic rv64);
    case (f3)
      3'b000, 3'b001, 3'b010: return 1'b1;
      3'b011:                 return rv64;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/npc_ctrl_fsm_if.sv
// IFU and LSU request/response handshakes seen by the NPC control unit.
interface npc_ctrl_fsm_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic        ifu_resp_valid;
  logic [31:0] ifu_resp_inst;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_req_we;
  logic [1:0]  lsu_req_size;
  logic        lsu_req_unsigned;
  logic        lsu_resp_valid;

  modport master (
    output ifu_req_valid,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_inst,
    output lsu_req_valid, lsu_req_we, lsu_req_size, lsu_req_unsigned,
    input  lsu_req_ready, lsu_resp_valid
  );

  modport slave (
    input  ifu_req_valid,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_inst,
    input  lsu_req_valid, lsu_req_we, lsu_req_size, lsu_req_unsigned,
    output lsu_req_ready, lsu_resp_valid
  );
endinterface

// File: rtl/npc_ctrl_decode.sv
// Combinational decode of the latched instruction into control fields.
// Undecodable words yield an all-zero bundle (legal=0) so a cleared inst reads as idle.
module npc_ctrl_decode
  import npc_ctrl_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned ALU_OP_W = 12
) (
  input  logic [31:0]         inst_i,
  output dec_t                dec_o,
  output logic [ALU_OP_W-1:0] alu_op_o
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       rv64;

  assign opcode = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign rv64   = (XLEN == 64);

  always_comb begin
    dec_o    = '0;
    alu_op_o = '0;
    case (opcode)
      OPC_OPIMM: if (f3 == F3_ADDI) begin
        dec_o.legal = 1'b1; dec_o.rf_we = 1'b1;
        dec_o.src1  = SRC1_RS1; dec_o.src2 = SRC2_IMM_IS; dec_o.npc = NPC_SEQ;
        alu_op_o[ALU_ADD_BIT] = 1'b1;
      end
      OPC_LUI: begin
        dec_o.legal = 1'b1; dec_o.rf_we = 1'b1;
        dec_o.src2  = SRC2_IMM_U; dec_o.npc = NPC_SEQ;
        alu_op_o[ALU_OP_W-1] = 1'b1;
      end
      OPC_AUIPC: begin
        dec_o.legal = 1'b1; dec_o.rf_we = 1'b1;
        dec_o.src1  = SRC1_PC; dec_o.src2 = SRC2_IMM_U; dec_o.npc = NPC_SEQ;
        alu_op_o[ALU_ADD_BIT] = 1'b1;
      end
      OPC_JAL: begin
        dec_o.legal = 1'b1; dec_o.rf_we = 1'b1;
        dec_o.src1  = SRC1_PC; dec_o.src2 = SRC2_CONST4; dec_o.npc = NPC_PC_IMM;
        alu_op_o[ALU_ADD_BIT] = 1'b1;
      end
      OPC_JALR: if (f3 == F3_JALR) begin
        dec_o.legal = 1'b1; dec_o.rf_we = 1'b1;
        dec_o.src1  = SRC1_PC; dec_o.src2 = SRC2_CONST4; dec_o.npc = NPC_JALR;
        alu_op_o[ALU_ADD_BIT] = 1'b1;
      end
      OPC_BRANCH: if (f3 == F3_BEQ || f3 == F3_BNE) begin
        dec_o.legal = 1'b1; dec_o.branch = 1'b1; dec_o.bne = (f3 == F3_BNE);
        dec_o.src1  = SRC1_RS1; dec_o.src2 = SRC2_RS2; dec_o.npc = NPC_SEQ;
        alu_op_o[ALU_SUB_BIT] = 1'b1;
      end
      OPC_LOAD: if (load_ok(f3, rv64)) begin
        dec_o.legal = 1'b1; dec_o.mem = 1'b1; dec_o.rf_we = 1'b1; dec_o.rfwd_load = 1'b1;
        dec_o.src1  = SRC1_RS1; dec_o.src2 = SRC2_IMM_IS; dec_o.npc = NPC_SEQ;
        dec_o.mem_size = f3[1:0]; dec_o.mem_unsigned = f3[2];
        alu_op_o[ALU_ADD_BIT] = 1'b1;
      end
      OPC_STORE: if (store_ok(f3, rv64)) begin
        dec_o.legal = 1'b1; dec_o.mem = 1'b1; dec_o.store = 1'b1;
        dec_o.src1  = SRC1_RS1; dec_o.src2 = SRC2_IMM_IS; dec_o.npc = NPC_SEQ;
        dec_o.mem_size = f3[1:0];
        alu_op_o[ALU_ADD_BIT] = 1'b1;
      end
      OPC_SYSTEM: if (inst_i == INST_EBREAK) begin
        dec_o.legal = 1'b1; dec_o.ebreak = 1'b1; dec_o.npc = NPC_SEQ;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/npc_ctrl_fsm.sv
// NPC multi-cycle control unit: fetch/execute/memory/writeback FSM around npc_ctrl_decode.
// Optional NPC_CTRL_PERF_EN adds 64-bit cycle and retired-instruction counters.
module npc_ctrl_fsm
  import npc_ctrl_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned ALU_OP_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  npc_ctrl_fsm_if.master      bus,
  input  logic                br_eq,
  output logic [31:0]         inst_o,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          sel_alusrc1,
  output logic [3:0]          sel_alusrc2,
  output logic [1:0]          sel_rfwd,
  output logic [2:0]          sel_nextpc,
  output logic                rf_we,
  output logic                pc_we,
  output logic                halt,
`ifdef NPC_CTRL_PERF_EN
  output logic                illegal,
  output logic [63:0]         perf_cycle,
  output logic [63:0]         perf_instret
`else
  output logic                illegal
`endif
);

  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic        halt_q, halt_d;
  logic        illegal_q, illegal_d;
  dec_t        dec;

  npc_ctrl_decode #(.XLEN(XLEN), .ALU_OP_W(ALU_OP_W)) u_decode (
    .inst_i   (inst_q),
    .dec_o    (dec),
    .alu_op_o (alu_op)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      inst_q    <= '0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      halt_q    <= halt_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    inst_d            = inst_q;
    halt_d            = halt_q;
    illegal_d         = illegal_q;
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    rf_we             = 1'b0;
    pc_we             = 1'b0;
    case (state_q)
      ST_IDLE:      state_d = ST_FETCH_REQ;
      ST_FETCH_REQ: begin
        bus.ifu_req_valid = 1'b1;
        if (bus.ifu_req_ready) state_d = ST_FETCH_WAIT;
      end
      ST_FETCH_WAIT: if (bus.ifu_resp_valid) begin
        inst_d  = bus.ifu_resp_inst;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (!dec.legal) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end else if (dec.ebreak) begin
          halt_d  = 1'b1;
          state_d = ST_HALT;
        end else if (dec.mem) begin
          state_d = ST_MEM_REQ;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM_REQ: begin
        bus.lsu_req_valid = 1'b1;
        if (bus.lsu_req_ready) state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT:  if (bus.lsu_resp_valid) state_d = ST_WB;
      ST_WB: begin
        rf_we   = dec.rf_we;
        pc_we   = 1'b1;
        state_d = ST_FETCH_REQ;
      end
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Request attributes come straight from the latched instruction, so they stay stable while waiting
  assign bus.lsu_req_we       = dec.store;
  assign bus.lsu_req_size     = dec.mem_size;
  assign bus.lsu_req_unsigned = dec.mem_unsigned;

  assign inst_o      = inst_q;
  assign sel_alusrc1 = dec.src1;
  assign sel_alusrc2 = dec.src2;
  assign sel_rfwd    = {1'b0, dec.rfwd_load};
  assign sel_nextpc  = (dec.branch && (dec.bne ^ br_eq)) ? NPC_PC_IMM : dec.npc;
  assign halt        = halt_q;
  assign illegal     = illegal_q;

`ifdef NPC_CTRL_PERF_EN
  logic [63:0] cycle_q, instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != ST_IDLE && state_q != ST_HALT) cycle_q <= cycle_q + 64'd1;
      if (state_q == ST_WB) instret_q <= instret_q + 64'd1;
    end
  end

  assign perf_cycle   = cycle_q;
  assign perf_instret = instret_q;
`endif

endmodule

// File: tb/tb_npc_ctrl_fsm.sv
// Directed bench for npc_ctrl_fsm: RV64 instance for the main flow, RV32 instance for ld legality.
`timescale 1ns/1ps
module tb_npc_ctrl_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic br_eq = 1'b0;
  int   total = 0;
  int   bad   = 0;

  npc_ctrl_fsm_if bus();
  npc_ctrl_fsm_if bus32();

  logic [31:0] inst_o, inst_o_32;
  logic [11:0] alu_op, alu_op_32;
  logic [1:0]  sel_alusrc1, sel_alusrc1_32, sel_rfwd, sel_rfwd_32;
  logic [3:0]  sel_alusrc2, sel_alusrc2_32;
  logic [2:0]  sel_nextpc, sel_nextpc_32;
  logic        rf_we, pc_we, halt, illegal;
  logic        rf_we_32, pc_we_32, halt_32, illegal_32;
`ifdef NPC_CTRL_PERF_EN
  logic [63:0] perf_cycle, perf_instret, perf_cycle_32, perf_instret_32;
`endif

  npc_ctrl_fsm #(.XLEN(64), .ALU_OP_W(12)) dut (
    .clk(clk), .rst(rst), .bus(bus), .br_eq(br_eq), .inst_o(inst_o), .alu_op(alu_op),
    .sel_alusrc1(sel_alusrc1), .sel_alusrc2(sel_alusrc2), .sel_rfwd(sel_rfwd),
    .sel_nextpc(sel_nextpc), .rf_we(rf_we), .pc_we(pc_we), .halt(halt),
`ifdef NPC_CTRL_PERF_EN
    .perf_cycle(perf_cycle), .perf_instret(perf_instret),
`endif
    .illegal(illegal)
  );

  npc_ctrl_fsm #(.XLEN(32), .ALU_OP_W(12)) dut32 (
    .clk(clk), .rst(rst), .bus(bus32), .br_eq(br_eq), .inst_o(inst_o_32), .alu_op(alu_op_32),
    .sel_alusrc1(sel_alusrc1_32), .sel_alusrc2(sel_alusrc2_32), .sel_rfwd(sel_rfwd_32),
    .sel_nextpc(sel_nextpc_32), .rf_we(rf_we_32), .pc_we(pc_we_32), .halt(halt_32),
`ifdef NPC_CTRL_PERF_EN
    .perf_cycle(perf_cycle_32), .perf_instret(perf_instret_32),
`endif
    .illegal(illegal_32)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {bus.ifu_req_valid, bus.lsu_req_valid, bus.lsu_req_we, bus.lsu_req_size,
        bus.lsu_req_unsigned, rf_we, pc_we, halt, illegal, sel_alusrc1, sel_alusrc2, sel_rfwd,
        sel_nextpc, alu_op}, 64'd0);
    chk({tag, "_inst"}, inst_o, 64'd0);
  endtask

  // Expects to be in FETCH_REQ; leaves the DUT in EXEC with inst latched
  task automatic fetch(input logic [31:0] inst);
    chk("fetch_req_valid", bus.ifu_req_valid, 1);
    bus.ifu_req_ready = 1'b1;
    step();
    bus.ifu_req_ready = 1'b0;
    chk("fetch_wait_no_req", bus.ifu_req_valid, 0);
    bus.ifu_resp_valid = 1'b1;
    bus.ifu_resp_inst  = inst;
    step();
    bus.ifu_resp_valid = 1'b0;
    chk("inst_latched", inst_o, inst);
  endtask

  initial begin
    bus.ifu_req_ready = 0; bus.ifu_resp_valid = 0; bus.ifu_resp_inst = '0;
    bus.lsu_req_ready = 0; bus.lsu_resp_valid = 0;
    bus32.ifu_req_ready = 0; bus32.ifu_resp_valid = 0; bus32.ifu_resp_inst = '0;
    bus32.lsu_req_ready = 0; bus32.lsu_resp_valid = 0;

    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
`ifdef NPC_CTRL_PERF_EN
    chk("perf_reset", {perf_cycle[31:0], perf_instret[31:0]}, 64'd0);
`endif
    rst = 1'b0;
    step();

    // addi x1,x0,5
    fetch(32'h0050_0093);
    chk("addi_exec_alu", alu_op, 12'h001);
    chk("addi_exec_src", {sel_alusrc1, sel_alusrc2}, 6'b01_0010);
    chk("addi_exec_we", {rf_we, pc_we}, 2'b00);
    step();
    chk("addi_wb", {rf_we, pc_we, sel_nextpc, sel_rfwd}, 7'b11_001_00);
    step();
    chk("addi_next_fetch", {bus.ifu_req_valid, rf_we, pc_we}, 3'b100);
    chk("addi_alu_held", alu_op, 12'h001);

    // ld x3,0(x2) with lsu_req_ready held off for 3 cycles
    fetch(32'h0001_3183);
    chk("ld_exec", {bus.lsu_req_valid, alu_op}, {1'b0, 12'h001});
    step();
    for (int i = 0; i < 3; i++) begin
      chk("ld_req_hold", {bus.lsu_req_valid, bus.lsu_req_we, bus.lsu_req_size, bus.lsu_req_unsigned}, 5'b1_0_11_0);
      step();
    end
    chk("ld_req_last", {bus.lsu_req_valid, bus.lsu_req_we, bus.lsu_req_size}, 4'b1_0_11);
    bus.lsu_req_ready = 1'b1;
    step();
    bus.lsu_req_ready = 1'b0;
    chk("ld_mem_wait", {bus.lsu_req_valid, rf_we}, 2'b00);
    bus.lsu_resp_valid = 1'b1;
    step();
    bus.lsu_resp_valid = 1'b0;
    chk("ld_wb", {rf_we, pc_we, sel_rfwd, sel_nextpc}, 7'b11_01_001);
    step();

    // sd x1,8(x2)
    fetch(32'h0011_3423);
    step();
    chk("sd_req", {bus.lsu_req_valid, bus.lsu_req_we, bus.lsu_req_size}, 4'b1_1_11);
    bus.lsu_req_ready = 1'b1;
    step();
    bus.lsu_req_ready = 1'b0;
    bus.lsu_resp_valid = 1'b1;
    step();
    bus.lsu_resp_valid = 1'b0;
    chk("sd_wb", {rf_we, pc_we}, 2'b01);
    step();

    // beq x0,x0,8 taken then not taken
    fetch(32'h0000_0463);
    chk("beq_exec", {alu_op, sel_alusrc1, sel_alusrc2}, {12'h002, 2'b01, 4'b0001});
    br_eq = 1'b1;
    step();
    chk("beq_taken_wb", {rf_we, pc_we, sel_nextpc}, 5'b01_010);
    step();
    fetch(32'h0000_0463);
    br_eq = 1'b0;
    step();
    chk("beq_not_taken_wb", {rf_we, pc_we, sel_nextpc}, 5'b01_001);
    step();

    // bne x0,x0,8 with br_eq=0 is taken
    fetch(32'h0000_1463);
    step();
    chk("bne_taken_wb", {rf_we, pc_we, sel_nextpc}, 5'b01_010);
    step();

    // jal x1,0
    fetch(32'h0000_00EF);
    chk("jal_exec", {alu_op, sel_alusrc1, sel_alusrc2}, {12'h001, 2'b10, 4'b1000});
    step();
    chk("jal_wb", {rf_we, pc_we, sel_nextpc}, 5'b11_010);
    step();

    // Reset during MEM_WAIT, then a stale LSU response after release
    fetch(32'h0001_3183);
    step();
    bus.lsu_req_ready = 1'b1;
    step();
    bus.lsu_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk_zero("rst_mid_mem");
    bus.lsu_resp_valid = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_fetch", {bus.ifu_req_valid, bus.lsu_req_valid, rf_we, pc_we}, 4'b1000);
    fetch(32'h0050_0093);
    chk("post_rst_exec", {bus.lsu_req_valid, alu_op}, {1'b0, 12'h001});
    step();
    chk("post_rst_wb", {rf_we, pc_we, bus.lsu_req_valid}, 3'b110);
    bus.lsu_resp_valid = 1'b0;
    step();

    // ebreak: sticky halt, no further requests even with a willing IFU
    fetch(32'h0010_0073);
    chk("ebreak_exec_halt", halt, 0);
    step();
    chk("ebreak_halt", {halt, illegal}, 2'b10);
    bus.ifu_req_ready = 1'b1;
    bus.ifu_resp_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("halt_no_req", {bus.ifu_req_valid, bus.lsu_req_valid, halt, pc_we}, 4'b0010);
      step();
    end
    bus.ifu_req_ready = 1'b0;
    bus.ifu_resp_valid = 1'b0;

    // All-zero word is illegal
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    fetch(32'h0000_0000);
    step();
    chk("zero_illegal", {illegal, halt}, 2'b10);
    step();
    chk("zero_illegal_stuck", {bus.ifu_req_valid, bus.lsu_req_valid, illegal}, 3'b001);

    // RV32 instance: ld is illegal
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("rv32_fetch_req", bus32.ifu_req_valid, 1);
    bus32.ifu_req_ready = 1'b1;
    step();
    bus32.ifu_req_ready = 1'b0;
    bus32.ifu_resp_valid = 1'b1;
    bus32.ifu_resp_inst = 32'h0001_3183;
    step();
    bus32.ifu_resp_valid = 1'b0;
    chk("rv32_ld_inst", inst_o_32, 32'h0001_3183);
    step();
    chk("rv32_ld_illegal", {illegal_32, halt_32}, 2'b10);
    bus32.ifu_req_ready = 1'b1;
    bus32.lsu_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rv32_no_req", {bus32.ifu_req_valid, bus32.lsu_req_valid, pc_we_32, rf_we_32}, 4'b0000);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
